// File: rtl/ws2812b_byte_transmitter.sv
`timescale 1ns/1ps
// WS2812B byte transmitter: sends bytes MSB first as T0H/T1H-cycle high pulses in TBIT-cycle
// slots, and inserts a TRESET-cycle low latch period on request between frames.
module ws2812b_byte_transmitter #(
    parameter int T0H    = 26,
    parameter int T1H    = 51,
    parameter int TBIT   = 80,
    parameter int TRESET = 3200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    input  logic       latch_req,
    output logic       busy,
    output logic       latch_done,
    output logic       dout
);

    localparam logic [11:0] T0H_C       = 12'(T0H);
    localparam logic [11:0] T1H_C       = 12'(T1H);
    localparam logic [11:0] TBIT_LAST   = 12'(TBIT - 1);
    localparam logic [11:0] TRESET_LAST = 12'(TRESET - 1);

    typedef enum logic [1:0] {IDLE, BIT, LATCH} state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  shift_q, shift_d;
    logic        latchPending_q, latchPending_d;
    logic        dout_q, dout_d;
    logic        latchDone_q, latchDone_d;
    logic        lastBitEnd;
    logic        accept;

    // A new byte may follow the final bit cycle directly, which gives seamless streaming.
    assign lastBitEnd = (state_q == BIT) && (bitIdx_q == 3'd7) && (cnt_q == TBIT_LAST);
    assign byte_ready = !reset && ((state_q == IDLE) || lastBitEnd) && !latchPending_q && !latch_req;
    assign accept     = byte_valid && byte_ready;
    assign busy       = (state_q != IDLE);
    assign latch_done = latchDone_q;
    assign dout       = dout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bitIdx_q       <= '0;
            shift_q        <= '0;
            latchPending_q <= 1'b0;
            dout_q         <= 1'b0;
            latchDone_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bitIdx_q       <= bitIdx_d;
            shift_q        <= shift_d;
            latchPending_q <= latchPending_d;
            dout_q         <= dout_d;
            latchDone_q    <= latchDone_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bitIdx_d       = bitIdx_q;
        shift_d        = shift_q;
        latchPending_d = latchPending_q;
        latchDone_d    = 1'b0;

        if (latch_req && (state_q != LATCH)) latchPending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (latch_req || latchPending_q) begin
                    state_d        = LATCH;
                    cnt_d          = '0;
                    latchPending_d = 1'b0;
                end else if (accept) begin
                    state_d  = BIT;
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    shift_d  = byte_data;
                end
            end
            BIT: begin
                if (accept) begin
                    state_d  = BIT;
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    shift_d  = byte_data;
                end else if (cnt_q == TBIT_LAST) begin
                    cnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        if (latchPending_q) begin
                            state_d        = LATCH;
                            latchPending_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        shift_d  = {shift_q[6:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            LATCH: begin
                if (cnt_q == TRESET_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    latchDone_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // dout is registered from the next-state slot position, so the line never glitches.
        dout_d = (state_d == BIT) && (cnt_d < (shift_d[7] ? T1H_C : T0H_C));
    end

endmodule

// File: tb/tb_ws2812b_byte_transmitter.sv
`timescale 1ns/1ps
// Self-checking bench for ws2812b_byte_transmitter: table of single bytes, hand-written
// streaming/latch/reset sequences, and random bytes checked against a pulse-width model.
module tb_ws2812b_byte_transmitter;

    localparam int T0H    = 26;
    localparam int T1H    = 51;
    localparam int TBIT   = 80;
    localparam int TRESET = 3200;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data  = 8'h00;
    logic       latch_req  = 1'b0;
    logic       byte_ready;
    logic       busy;
    logic       latch_done;
    logic       dout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        int         expHigh;
    } vec_t;

    ws2812b_byte_transmitter #(
        .T0H(T0H),
        .T1H(T1H),
        .TBIT(TBIT),
        .TRESET(TRESET)
    ) dut (
        .clk(clk),
        .reset(reset),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .latch_req(latch_req),
        .busy(busy),
        .latch_done(latch_done),
        .dout(dout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: every accepted byte becomes eight expected high widths, MSB first.
    int expWidth[$];
    int runLen    = 0;
    int sinceRise = 0;
    int pulseIdx  = 0;
    logic prevHigh = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                expWidth.delete();
                runLen    = 0;
                sinceRise = 0;
                pulseIdx  = 0;
                prevHigh  = 1'b0;
            end else begin
                if (byte_valid && byte_ready)
                    for (int b = 7; b >= 0; b--) expWidth.push_back(byte_data[b] ? T1H : T0H);
                sinceRise++;
                if (dout && !prevHigh) begin
                    if (pulseIdx % 8 != 0) checkOutput("bitPeriod", sinceRise, TBIT);
                    sinceRise = 0;
                    runLen    = 1;
                end else if (dout) begin
                    runLen++;
                end else if (prevHigh) begin
                    if (expWidth.size() == 0) checkOutput("unexpectedPulse", runLen, 0);
                    else checkOutput("highTime", runLen, expWidth.pop_front());
                    pulseIdx++;
                end
                prevHigh = dout;
            end
        end
    end

    // Presents a byte and holds it until accepted; returns just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] d, input logic keepValid, input logic [7:0] nextData);
        int waited = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        forever begin
            @(negedge clk);
            if (byte_ready) break;
            waited++;
            if (waited > 5000) begin
                checkOutput("acceptTimeout", waited, 0);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        byte_valid = keepValid;
        byte_data  = keepValid ? nextData : 8'($urandom);
    endtask

    task automatic waitIdle(output int busyCnt, output int highCnt);
        logic done = 1'b0;
        busyCnt = 0;
        highCnt = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            busyCnt++;
            if (dout) highCnt++;
        end
        if (!done) checkOutput("idleTimeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic observe(input int nCycles, input int l1, input int l2, input int lo, input int hi,
                           output int firstReady, output int ldCount, output int ldCyc,
                           output int highWin, output int busyCount);
        firstReady = -1;
        ldCount    = 0;
        ldCyc      = -1;
        highWin    = 0;
        busyCount  = 0;
        for (int k = 0; k < nCycles; k++) begin
            logic drop = 1'b0;
            @(negedge clk);
            if (byte_valid && byte_ready && firstReady < 0) begin
                firstReady = k;
                drop       = 1'b1;
            end
            if (latch_done) begin
                ldCount++;
                ldCyc = k;
            end
            if (k >= lo && k <= hi && dout) highWin++;
            if (busy) busyCount++;
            @(posedge clk);
            #1;
            latch_req = ((k + 1) == l1) || ((k + 1) == l2);
            if (drop) byte_valid = 1'b0;
        end
    endtask

    // Main sequence: reset, table, hand-written corner cases, random traffic, summary.
    initial begin
        vec_t vecs[6];
        int bc, hc, fr, ldc, ldk, hw, bsy, gap;

        vecs[0] = '{8'hA5, 4*T1H + 4*T0H};
        vecs[1] = '{8'hFF, 8*T1H};
        vecs[2] = '{8'h00, 8*T0H};
        vecs[3] = '{8'h80, T1H + 7*T0H};
        vecs[4] = '{8'h01, T1H + 7*T0H};
        vecs[5] = '{8'hE0, 3*T1H + 5*T0H};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_latchDone", latch_done, 0);
        checkOutput("rst_ready", byte_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", byte_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].data, 1'b0, 8'h00);
            waitIdle(bc, hc);
            checkOutput($sformatf("vec%0d_busyCycles", i), bc, 8*TBIT);
            checkOutput($sformatf("vec%0d_highCycles", i), hc, vecs[i].expHigh);
        end

        applyStimulus(8'hFF, 1'b1, 8'h00);
        gap = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (byte_valid && byte_ready) begin
                gap = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        checkOutput("stream_secondAccept", gap, 8*TBIT);
        waitIdle(bc, hc);
        checkOutput("stream_busy2", bc, 8*TBIT);
        checkOutput("stream_high2", hc, 8*T0H);

        applyStimulus(8'h55, 1'b1, 8'hC3);
        observe(2*8*TBIT + TRESET + 20, 299, -1, 8*TBIT, 8*TBIT + TRESET, fr, ldc, ldk, hw, bsy);
        checkOutput("midLatch_readyAt", fr, 8*TBIT + TRESET);
        checkOutput("midLatch_doneCount", ldc, 1);
        checkOutput("midLatch_doneAt", ldk, 8*TBIT + TRESET);
        checkOutput("midLatch_lowHigh", hw, 0);
        checkOutput("midLatch_busy", bsy, 2*8*TBIT + TRESET);

        byte_valid = 1'b1;
        byte_data  = 8'h96;
        latch_req  = 1'b1;
        observe(TRESET + 8*TBIT + 20, -1, -1, 1, TRESET + 1, fr, ldc, ldk, hw, bsy);
        checkOutput("sameCycle_readyAt", fr, TRESET + 1);
        checkOutput("sameCycle_doneCount", ldc, 1);
        checkOutput("sameCycle_doneAt", ldk, TRESET + 1);
        checkOutput("sameCycle_lowHigh", hw, 0);
        checkOutput("sameCycle_busy", bsy, TRESET + 8*TBIT);

        latch_req = 1'b1;
        observe(2*TRESET + 100, 100, TRESET, 0, 2*TRESET + 100, fr, ldc, ldk, hw, bsy);
        checkOutput("latchIgnore_doneCount", ldc, 1);
        checkOutput("latchIgnore_doneAt", ldk, TRESET + 1);
        checkOutput("latchIgnore_busy", bsy, TRESET);
        checkOutput("latchIgnore_high", hw, 0);

        applyStimulus(8'h80, 1'b0, 8'h00);
        repeat (3*TBIT + 10) @(posedge clk);
        #1;
        checkOutput("preReset_dout", dout, 1);
        checkOutput("preReset_busy", busy, 1);
        byte_valid = 1'b1;
        byte_data  = 8'h33;
        reset      = 1'b1;
        #1;
        checkOutput("asyncReset_dout", dout, 0);
        checkOutput("asyncReset_busy", busy, 0);
        checkOutput("asyncReset_ready", byte_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        reset      = 1'b0;
        byte_valid = 1'b0;
        applyStimulus(8'h01, 1'b0, 8'h00);
        waitIdle(bc, hc);
        checkOutput("postReset_busy", bc, 8*TBIT);
        checkOutput("postReset_high", hc, T1H + 7*T0H);

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(8'($urandom), 1'b0, 8'h00);
        end
        waitIdle(bc, hc);
        checkOutput("queueDrained", expWidth.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
